// File: rtl/round_key_collector.sv
// Round-key collector: captures key-SRAM read words and packs groups of four into 128-bit keys.
// Keys are buffered in a FIFO and offered to the round core by valid/ready. Optional head parity check: KEY_COLLECT_PARITY_EN.
module round_key_collector #(
    parameter int RD_LAT   = 1,
    parameter int DEPTH    = 4,
    parameter int NUM_KEYS = 11
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         r_en,
    input  logic [31:0]  rdata,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         all_done,
    output logic         ovf
`ifdef KEY_COLLECT_PARITY_EN
    ,
    output logic         par_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] NK = 4'(NUM_KEYS);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    logic [RD_LAT-1:0] rd_pipe;
    logic              cap;
    logic [1:0]        wcnt;
    logic [3:0]        kcnt;
    logic [3:0]        pop_cnt;
    logic [3:0]        drop_cnt;
    logic [3:0]        pop_cnt_nxt;
    logic [31:0]       w0, w1, w2;

    logic [AW:0]       wr_ptr, rd_ptr;
    logic [AW-1:0]     wr_idx, rd_idx;
    logic [127:0]      key_mem [DEPTH];
    logic [3:0]        idx_mem [DEPTH];
`ifdef KEY_COLLECT_PARITY_EN
    logic              par_mem [DEPTH];
`endif

    logic cap_en, push, pop, full, empty, accept, drop;

    assign cap    = rd_pipe[RD_LAT-1];
    assign cap_en = cap && (state == COLLECT) && !start;
    assign push   = cap_en && (wcnt == 2'd3);

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign pop    = !empty && key_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    // NOTE: always_comb outputs get a default first so no path can infer a latch.
    always_comb begin
        pop_cnt_nxt = pop_cnt;
        if (pop && (pop_cnt != NK)) begin
            pop_cnt_nxt = pop_cnt + 4'd1;
        end
    end

    // NOTE: word slots and FIFO storage have no reset; key_valid gates everything read from them.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            case (wcnt)
                2'd0:    w0 <= rdata;
                2'd1:    w1 <= rdata;
                2'd2:    w2 <= rdata;
                default: ;
            endcase
        end
        if (accept) begin
            key_mem[wr_idx] <= {w0, w1, w2, rdata};
            idx_mem[wr_idx] <= kcnt;
`ifdef KEY_COLLECT_PARITY_EN
            par_mem[wr_idx] <= ^{w0, w1, w2, rdata};
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            rd_pipe  <= '0;
            wcnt     <= '0;
            kcnt     <= '0;
            pop_cnt  <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            all_done <= 1'b0;
        end else if (start) begin
            state    <= COLLECT;
            rd_pipe  <= '0;
            wcnt     <= '0;
            kcnt     <= '0;
            pop_cnt  <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            all_done <= 1'b0;
        end else begin
            rd_pipe[0] <= r_en;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end

            if (cap_en) begin
                wcnt <= wcnt + 2'd1;
            end
            if (push && (kcnt != NK)) begin
                kcnt <= kcnt + 4'd1;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            pop_cnt <= pop_cnt_nxt;
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != NK) begin
                    drop_cnt <= drop_cnt + 4'd1;
                end
            end

            case (state)
                IDLE: ;
                COLLECT: begin
                    if (push && (kcnt == NK - 4'd1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Dropped keys will never be popped, so they count toward completion.
                    if ((pop_cnt_nxt == NK) ||
                        ({1'b0, drop_cnt} + {1'b0, pop_cnt_nxt} == {1'b0, NK})) begin
                        state    <= DONE;
                        all_done <= 1'b1;
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign key_valid = !empty;
    assign round_key = key_valid ? key_mem[rd_idx] : '0;
    assign round_idx = key_valid ? idx_mem[rd_idx] : '0;
`ifdef KEY_COLLECT_PARITY_EN
    assign par_err   = key_valid && ((^key_mem[rd_idx]) != par_mem[rd_idx]);
`endif

endmodule

// File: tb/tb_round_key_collector.sv
// Directed bench for round_key_collector: basic stream, latency (RD_LAT=2), backpressure/overflow,
// full with simultaneous push/pop, restart, async reset, and parity when KEY_COLLECT_PARITY_EN is defined.
module tb_round_key_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         n_rst, start, r_en, key_ready;
    logic [31:0]  rdata;
    logic         key_valid, all_done, ovf;
    logic [127:0] round_key;
    logic [3:0]   round_idx;

    logic         start2, r_en2, key_ready2;
    logic [31:0]  rdata2;
    logic         key_valid2, all_done2, ovf2;
    logic [127:0] round_key2;
    logic [3:0]   round_idx2;
`ifdef KEY_COLLECT_PARITY_EN
    logic         par_err, par_err2;
`endif

    int total = 0;
    int bad   = 0;

    round_key_collector #(.RD_LAT(1), .DEPTH(4), .NUM_KEYS(11)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .r_en(r_en), .rdata(rdata),
        .key_ready(key_ready), .key_valid(key_valid), .round_key(round_key),
        .round_idx(round_idx), .all_done(all_done), .ovf(ovf)
`ifdef KEY_COLLECT_PARITY_EN
        , .par_err(par_err)
`endif
    );

    round_key_collector #(.RD_LAT(2), .DEPTH(4), .NUM_KEYS(11)) dut2 (
        .clk(clk), .n_rst(n_rst), .start(start2), .r_en(r_en2), .rdata(rdata2),
        .key_ready(key_ready2), .key_valid(key_valid2), .round_key(round_key2),
        .round_idx(round_idx2), .all_done(all_done2), .ovf(ovf2)
`ifdef KEY_COLLECT_PARITY_EN
        , .par_err(par_err2)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    function automatic logic [127:0] mk_key(input logic [31:0] b);
        return {b, b + 32'd1, b + 32'd2, b + 32'd3};
    endfunction

    // 44 consecutive reads; word n arrives one cycle after its strobe and carries base+n.
    task automatic stream_basic(input logic [31:0] base, input string tag);
        key_ready = 1'b1;
        for (int c = 0; c <= 46; c++) begin
            r_en  = (c < 44);
            rdata = (c >= 1 && c <= 44) ? base + 32'(c - 1) : 32'h0;
            if (c >= 5 && c <= 45 && (c - 5) % 4 == 0) begin
                check({tag, "_valid"}, 128'(key_valid), 128'd1);
                check({tag, "_idx"}, 128'(round_idx), 128'((c - 5) / 4));
                check({tag, "_key"}, round_key, mk_key(base + 32'(c - 5)));
            end
            if (c == 6)  check({tag, "_popped"}, 128'(key_valid), 128'd0);
            if (c == 45) check({tag, "_done_early"}, 128'(all_done), 128'd0);
            if (c == 46) begin
                check({tag, "_done"}, 128'(all_done), 128'd1);
                check({tag, "_empty"}, 128'(key_valid), 128'd0);
                check({tag, "_ovf"}, 128'(ovf), 128'd0);
            end
            cyc();
        end
        r_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst = 1'b0; start = 1'b0; r_en = 1'b0; rdata = '0; key_ready = 1'b0;
        start2 = 1'b0; r_en2 = 1'b0; rdata2 = '0; key_ready2 = 1'b0;

        // Reset state
        #12;
        check("rst_valid", 128'(key_valid), 128'd0);
        check("rst_key", round_key, 128'd0);
        check("rst_idx", 128'(round_idx), 128'd0);
        check("rst_done", 128'(all_done), 128'd0);
        check("rst_ovf", 128'(ovf), 128'd0);
        #1 n_rst = 1'b1;
        cyc();

        // Reads in IDLE are ignored
        for (int c = 0; c < 8; c++) begin
            r_en  = (c < 4);
            rdata = 32'(c);
            cyc();
        end
        check("idle_ignore", 128'(key_valid), 128'd0);

        // Basic operation
        do_start();
        stream_basic(32'h0, "basic");
        cyc();
        cyc();
        check("done_held", 128'(all_done), 128'd1);

        // Latency with RD_LAT=2: key_valid 3 cycles after the 4th strobe
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            r_en2  = (c < 4);
            rdata2 = (c >= 2 && c <= 5) ? 32'hA5A5_0000 + 32'(c - 2) : 32'h0;
            if (c == 5) check("lat_early", 128'(key_valid2), 128'd0);
            if (c == 6) begin
                check("lat_valid", 128'(key_valid2), 128'd1);
                check("lat_key", round_key2, mk_key(32'hA5A5_0000));
                check("lat_idx", 128'(round_idx2), 128'd0);
            end
            if (c == 7) check("lat_stable", round_key2, mk_key(32'hA5A5_0000));
            cyc();
        end
        r_en2 = 1'b0;

        // Backpressure: FIFO holds rounds 0..3, later keys dropped
        do_start();
        key_ready = 1'b0;
        for (int c = 0; c <= 46; c++) begin
            r_en  = (c < 44);
            rdata = (c >= 1 && c <= 44) ? 32'(c - 1) : 32'h0;
            if (c == 20) check("bp_ovf_before", 128'(ovf), 128'd0);
            if (c == 21) check("bp_ovf_after", 128'(ovf), 128'd1);
            if (c == 46) begin
                check("bp_valid", 128'(key_valid), 128'd1);
                check("bp_head", 128'(round_idx), 128'd0);
                check("bp_not_done", 128'(all_done), 128'd0);
            end
            cyc();
        end
        r_en = 1'b0;
        key_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("bp_pop_idx", 128'(round_idx), 128'(j));
            check("bp_pop_key", round_key, mk_key(32'(4 * j)));
            cyc();
        end
        check("bp_drained", 128'(key_valid), 128'd0);
        check("bp_done", 128'(all_done), 128'd1);
        check("bp_ovf_sticky", 128'(ovf), 128'd1);

        // Full FIFO with push and pop on the same edge
        do_start();
        for (int c = 0; c <= 20; c++) begin
            r_en      = (c < 20);
            rdata     = (c >= 1) ? 32'(c - 1) : 32'h0;
            key_ready = (c == 20);
            if (c == 20) check("fs_head0", 128'(round_idx), 128'd0);
            cyc();
        end
        key_ready = 1'b0;
        check("fs_no_ovf", 128'(ovf), 128'd0);
        check("fs_head1", 128'(round_idx), 128'd1);
        cyc();
        key_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            check("fs_valid", 128'(key_valid), 128'd1);
            check("fs_idx", 128'(round_idx), 128'(j));
            check("fs_key", round_key, mk_key(32'(4 * j)));
            cyc();
        end
        check("fs_occupancy", 128'(key_valid), 128'd0);

        // Restart mid key 1
        do_start();
        key_ready = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            r_en  = (c < 6);
            rdata = (c >= 1) ? 32'h7700 + 32'(c - 1) : 32'h0;
            cyc();
        end
        check("rs_pre_valid", 128'(key_valid), 128'd1);
        do_start();
        check("rs_flushed", 128'(key_valid), 128'd0);
        check("rs_ovf", 128'(ovf), 128'd0);
        stream_basic(32'h1000, "restart");

        // Async reset while a key is valid
        do_start();
        key_ready = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            r_en  = (c < 4);
            rdata = (c >= 1) ? 32'h5500 + 32'(c - 1) : 32'h0;
            cyc();
        end
        check("ar_pre_valid", 128'(key_valid), 128'd1);
        #2 n_rst = 1'b0;
        #1;
        check("ar_valid", 128'(key_valid), 128'd0);
        check("ar_key", round_key, 128'd0);
        check("ar_idx", 128'(round_idx), 128'd0);
        check("ar_done", 128'(all_done), 128'd0);
        cyc();
        n_rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            r_en  = (c < 8);
            rdata = 32'(c);
            cyc();
        end
        check("ar_no_key", 128'(key_valid), 128'd0);

`ifdef KEY_COLLECT_PARITY_EN
        // Parity: corrupt the stored bit of the head entry
        do_start();
        key_ready = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            r_en  = (c < 8);
            rdata = (c >= 1) ? 32'h3C00 + 32'(c - 1) : 32'h0;
            cyc();
        end
        check("par_clean", 128'(par_err), 128'd0);
        dut.par_mem[0] = ~dut.par_mem[0];
        #1;
        check("par_flip", 128'(par_err), 128'd1);
        key_ready = 1'b1;
        cyc();
        key_ready = 1'b0;
        check("par_next_valid", 128'(key_valid), 128'd1);
        check("par_after_pop", 128'(par_err), 128'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
